// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Characterizes a 3-input combinational gate. On start it drives the eight
// input codes 000..111 onto dut_in, holding each for SETTLE_CYCLES clocks,
// samples dut_out at the end of each hold window and reassembles the gate's
// 8-bit truth-table code (code k lands in bit 7-k, so code 000 is the MSB).
// The result is compared against the expected code latched at start.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   start        : sweep request, accepted only while idle (including the
//                  done cycle, so back-to-back sweeps work)
//   expected     : reference truth-table code, latched when start is accepted
//   dut_in       : registered {in1,in2,in3} drive to the gate under test
//   dut_out      : gate output, assumed settled within SETTLE_CYCLES
//   busy         : high while a sweep is running
//   done         : one-cycle pulse in the first idle cycle after a sweep
//   truth_table  : result of the last completed sweep
//   match        : truth_table equals the latched expected code
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    output logic [2:0] dut_in,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       match
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q,   idx_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       exp_q,   exp_d;
    logic             done_q,  done_d;
    logic [7:0]       tt_q,    tt_d;
    logic             match_q, match_d;
    logic [2:0]       bitpos;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            shreg_q <= 8'h00;
            exp_q   <= 8'h00;
            done_q  <= 1'b0;
            tt_q    <= 8'h00;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            exp_q   <= exp_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
            match_q <= match_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        exp_d   = exp_q;
        done_d  = 1'b0;
        tt_d    = tt_q;
        match_d = match_q;
        bitpos  = 3'd7 - idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    exp_d   = expected;
                end
            end
            ST_SWEEP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d           = '0;
                    shreg_d[bitpos] = dut_out;
                    // idx wraps 7 -> 0 on the last capture, which also
                    // returns dut_in to 000 for the idle state.
                    idx_d           = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        // Publish the shreg value that includes this edge's bit.
                        tt_d    = shreg_d;
                        match_d = (shreg_d == exp_q);
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // dut_in tracks idx, which is itself a register, so the drive is glitch-free.
    assign dut_in      = idx_q;
    assign busy        = (state_q == ST_SWEEP);
    assign done        = done_q;
    assign truth_table = tt_q;
    assign match       = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Two sweeper instances (SETTLE_CYCLES=2 and =1) face a behavioural gate
// described as a list of outputs per input code. The expected truth table is
// built from that list; cycle-by-cycle busy/done/dut_in/result holding are
// checked against the documented timing.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] expected;
    logic       sel;          // 0: S=2 instance, 1: S=1 instance
    logic       outs [8];     // gate output for each input code

    logic       start_a, start_b;
    logic [2:0] dut_in_a, dut_in_b;
    logic       dut_out_a, dut_out_b;
    logic       busy_a, busy_b, done_a, done_b, match_a, match_b;
    logic [7:0] tt_a, tt_b;

    logic [2:0] o_dut_in;
    logic       o_busy, o_done, o_match;
    logic [7:0] o_tt;

    int         nvec;
    int         nerr;
    logic [7:0] prev_tt [2];
    logic       prev_m  [2];

    assign start_a   = start && !sel;
    assign start_b   = start && sel;
    assign dut_out_a = outs[dut_in_a];
    assign dut_out_b = outs[dut_in_b];

    assign o_dut_in = sel ? dut_in_b : dut_in_a;
    assign o_busy   = sel ? busy_b   : busy_a;
    assign o_done   = sel ? done_b   : done_a;
    assign o_match  = sel ? match_b  : match_a;
    assign o_tt     = sel ? tt_b     : tt_a;

    truth_table_sweeper #(.SETTLE_CYCLES(2)) u_s2 (
        .clk(clk), .rst(rst), .start(start_a), .expected(expected),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a),
        .done(done_a), .truth_table(tt_a), .match(match_a)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_b), .expected(expected),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b),
        .done(done_b), .truth_table(tt_b), .match(match_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gate(input logic [7:0] list_msb_first);
        // Bit 7 of the argument is the output for code 000.
        logic [7:0] l;
        l = list_msb_first;
        for (int k = 0; k < 8; k++) outs[k] = l[7-k];
    endtask

    task automatic set_gate_random();
        for (int k = 0; k < 8; k++) outs[k] = 1'($urandom_range(0, 1));
    endtask

    // Truth table as defined: code k contributes bit 7-k.
    function automatic logic [7:0] ref_tt();
        logic [7:0] t;
        t = 8'h00;
        for (int k = 0; k < 8; k++) t = {t[6:0], outs[k]};
        return t;
    endfunction

    // Runs one sweep on the selected instance. Returns in the done cycle so
    // the caller may immediately chain another sweep.
    task automatic sweep(input logic [7:0] e, input int ign);
        int         s;
        int         si;
        logic [7:0] r;
        s  = sel ? 1 : 2;
        si = sel ? 1 : 0;
        r  = ref_tt();
        start    = 1'b1;
        expected = e;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8 * s; c++) begin
            chk("busy_high", 32'(o_busy), 32'd1);
            chk("done_low", 32'(o_done), 32'd0);
            chk("dut_in_step", 32'(o_dut_in), 32'((c - 1) / s));
            chk("tt_hold", 32'(o_tt), 32'(prev_tt[si]));
            chk("match_hold", 32'(o_match), 32'(prev_m[si]));
            if (c == ign) begin
                start    = 1'b1;
                expected = 8'h00;
            end
            step();
            start = 1'b0;
        end
        chk("done_pulse", 32'(o_done), 32'd1);
        chk("busy_end", 32'(o_busy), 32'd0);
        chk("dut_in_end", 32'(o_dut_in), 32'd0);
        chk("truth_table", 32'(o_tt), 32'(r));
        chk("match", 32'(o_match), 32'(r == e));
        prev_tt[si] = r;
        prev_m[si]  = (r == e);
    endtask

    task automatic idle(input int n);
        int si;
        si = sel ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_done", 32'(o_done), 32'd0);
            chk("idle_busy", 32'(o_busy), 32'd0);
            chk("idle_tt", 32'(o_tt), 32'(prev_tt[si]));
            chk("idle_dut_in", 32'(o_dut_in), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] e;
        nvec       = 0;
        nerr       = 0;
        rst        = 1'b1;
        start      = 1'b0;
        expected   = 8'h00;
        sel        = 1'b0;
        prev_tt[0] = 8'h00;
        prev_tt[1] = 8'h00;
        prev_m[0]  = 1'b0;
        prev_m[1]  = 1'b0;
        set_gate(8'h00);

        // Reset state, both instances
        step(); step(); step();
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            #1;
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_done", 32'(o_done), 32'd0);
            chk("rst_tt", 32'(o_tt), 32'd0);
            chk("rst_match", 32'(o_match), 32'd0);
            chk("rst_dut_in", 32'(o_dut_in), 32'd0);
        end
        rst = 1'b0;
        sel = 1'b0;
        step();

        // 0xD2 gate, S=2
        set_gate(8'hD2);
        sweep(8'hD2, 0);
        idle(2);

        // Constant-1 gate, S=1: mismatch then match
        sel = 1'b1;
        set_gate(8'hFF);
        sweep(8'hD2, 0);
        idle(1);
        sweep(8'hFF, 0);
        idle(2);

        // start pulsed at cycle 5 with a different expected is ignored
        sel = 1'b0;
        set_gate(8'hD2);
        sweep(8'hD2, 5);
        idle(2);

        // Back-to-back sweeps: second start lands in the done cycle
        set_gate(8'h96);
        sweep(8'h96, 0);
        set_gate(8'h3C);
        sweep(8'h00, 0);
        idle(2);

        // Reset in cycle 9 of a sweep
        set_gate(8'hD2);
        start    = 1'b1;
        expected = 8'hD2;
        step();
        start = 1'b0;
        for (int c = 1; c < 9; c++) step();
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        chk("midrst_tt", 32'(o_tt), 32'd0);
        chk("midrst_match", 32'(o_match), 32'd0);
        chk("midrst_dut_in", 32'(o_dut_in), 32'd0);
        prev_tt[0] = 8'h00;
        prev_tt[1] = 8'h00;
        prev_m[0]  = 1'b0;
        prev_m[1]  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("no_done_after_rst", 32'(o_done), 32'd0);
        end
        sweep(8'hD2, 0);
        idle(1);

        // Randomized gates, instances, expected codes and idle gaps
        for (int n = 0; n < 10; n++) begin
            sel = 1'($urandom_range(0, 1));
            set_gate_random();
            if ($urandom_range(0, 1) == 1) e = ref_tt();
            else                           e = 8'($urandom);
            sweep(e, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : 0);
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
